// File: rtl/bist_pkg.sv
// Shared definitions for the BIST host and controller: FSM states, result codes
// and the default burst/loop parameters both sides must agree on.
package bist_pkg;

    localparam int BIST_N = 7;
    localparam int BIST_M = 10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_ACTIVE   = 3'd2,
        S_WAIT_END = 3'd3,
        S_DONE     = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd1;
    localparam logic [2:0] ERR_BURST_LEN = 3'd2;
    localparam logic [2:0] ERR_BURST_CNT = 3'd3;
    localparam logic [2:0] ERR_PROTO     = 3'd4;

    // Resolves simultaneous failures: timeout > protocol > burst length > burst count.
    function automatic logic [2:0] err_select(input logic timeout, input logic proto,
                                              input logic len_bad, input logic cnt_bad);
        logic [2:0] code;
        if (timeout) begin
            code = ERR_TIMEOUT;
        end else if (proto) begin
            code = ERR_PROTO;
        end else if (len_bad) begin
            code = ERR_BURST_LEN;
        end else if (cnt_bad) begin
            code = ERR_BURST_CNT;
        end else begin
            code = ERR_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/bist_burst_checker.sv
// Tracks mode bursts while the host is in ACTIVE: measures each burst, flags a
// wrong length at the falling edge and keeps saturating result counters.
module bist_burst_checker
    import bist_pkg::*;
#(
    parameter int N     = BIST_N,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             mode,
    output logic             len_err,
    output logic             burst_done,
    output logic             burst_open,
    output logic [CNT_W-1:0] mode_cycles,
    output logic [CNT_W-1:0] run_count
);
    localparam logic [CNT_W-1:0] LEN_OK = CNT_W'(N + 1);

    logic             mode_prev_r;
    logic [CNT_W-1:0] len_r;
    logic             fall_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Falling-edge classification against the expected burst length.
    always_comb begin
        fall_s     = enable & mode_prev_r & ~mode;
        len_err    = fall_s & (len_r != LEN_OK);
        burst_done = fall_s & (len_r == LEN_OK);
        burst_open = (len_r != {CNT_W{1'b0}});
    end

    // Burst length, edge history and result counters; frozen outside ACTIVE.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            mode_prev_r <= 1'b0;
            len_r       <= {CNT_W{1'b0}};
            mode_cycles <= {CNT_W{1'b0}};
            run_count   <= {CNT_W{1'b0}};
        end else if (enable) begin
            mode_prev_r <= mode;
            if (mode) begin
                len_r       <= sat_inc(len_r);
                mode_cycles <= sat_inc(mode_cycles);
            end else if (fall_s) begin
                len_r <= {CNT_W{1'b0}};
                if (burst_done) begin
                    run_count <= sat_inc(run_count);
                end
            end
        end
    end

endmodule

// File: rtl/bist_host.sv
// Initiator of a BIST run: raises bist_start once per request, supervises the
// controller's status sequence and reports pass/fail with measured counts.
module bist_host
    import bist_pkg::*;
#(
    parameter int N       = BIST_N,
    parameter int M       = BIST_M,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    output logic             bist_start,
    input  logic             init,
    input  logic             mode,
    input  logic             running,
    input  logic             finish,
    input  logic             bist_end,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] mode_cycles,
    output logic [CNT_W-1:0] run_count
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t          state_r;
    logic [WD_W-1:0] wdog_r;
    logic            clear_s;
    logic            len_err_s;
    logic            burst_done_s;
    logic            burst_open_s;
    logic            timeout_s;
    logic            proto_s;
    logic            cnt_err_s;
    logic [2:0]      err_s;

    assign clear_s = (state_r == S_IDLE) && req;

    bist_burst_checker #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_burst (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear_s),
        .enable      (state_r == S_ACTIVE),
        .mode        (mode),
        .len_err     (len_err_s),
        .burst_done  (burst_done_s),
        .burst_open  (burst_open_s),
        .mode_cycles (mode_cycles),
        .run_count   (run_count)
    );

    // Per-state fault detection; the watchdog fires on the cycle it would reach TIMEOUT.
    always_comb begin
        timeout_s = (wdog_r == WD_W'(TIMEOUT - 1));
        proto_s   = 1'b0;
        cnt_err_s = 1'b0;
        case (state_r)
            S_ACTIVE: begin
                proto_s   = (mode & ~running) | init | (finish & (mode | burst_open_s));
                cnt_err_s = finish & ~mode & ~burst_open_s & (run_count != CNT_W'(M + 1));
            end
            S_WAIT_END: begin
                proto_s = ~bist_end;
            end
            default: begin
                proto_s   = 1'b0;
                cnt_err_s = 1'b0;
            end
        endcase
        err_s = err_select(timeout_s, proto_s, len_err_s, cnt_err_s);
    end

    // Run sequencer with registered handshake and result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= S_IDLE;
            wdog_r     <= {WD_W{1'b0}};
            bist_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done       <= 1'b0;
                    bist_start <= 1'b0;
                    if (req) begin
                        pass       <= 1'b0;
                        err_code   <= ERR_NONE;
                        wdog_r     <= {WD_W{1'b0}};
                        busy       <= 1'b1;
                        bist_start <= 1'b1;
                        state_r    <= S_START;
                    end
                end
                S_START, S_ACTIVE, S_WAIT_END: begin
                    wdog_r <= wdog_r + {{(WD_W-1){1'b0}}, 1'b1};
                    if (err_s != ERR_NONE) begin
                        err_code   <= err_s;
                        done       <= 1'b1;
                        pass       <= 1'b0;
                        busy       <= 1'b0;
                        bist_start <= 1'b0;
                        state_r    <= S_ERROR;
                    end else if (state_r == S_START) begin
                        if (init) begin
                            bist_start <= 1'b0;
                            state_r    <= S_ACTIVE;
                        end
                    end else if (state_r == S_ACTIVE) begin
                        if (finish) begin
                            state_r <= S_WAIT_END;
                        end
                    end else begin
                        done    <= 1'b1;
                        pass    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= S_DONE;
                    end
                end
                S_DONE, S_ERROR: begin
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r    <= S_IDLE;
                    bist_start <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bist_host.md
Name: bist_host

Overview:
Initiator side of the BIST start/status interface. On a software/system request it issues a clean rising edge on bist_start to the BIST controller and watches the controller's init/mode/running/finish/bist_end outputs. It checks the pattern-burst sequence against parameters N and M, then reports pass/fail, an error code and measured counts. It sits between the system control logic and the BIST controller.

Parameters:
N, 7, controller burst parameter; expected mode-high burst length = N+1 cycles
M, 10, controller loop parameter; expected burst count = M+1
TIMEOUT, 1024, max cycles from bist_start rise to bist_end before abort
CNT_W, 16, width of the mode_cycles and run_count result counters

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
req  in  1  request a BIST run; sampled only when not busy
bist_start  out  1  start request to the controller
init  in  1  controller init status
mode  in  1  controller test-mode status
running  in  1  controller running status
finish  in  1  controller finish status
bist_end  in  1  controller end status
busy  out  1  run in progress
done  out  1  one-cycle pulse at run completion
pass  out  1  result valid after done; 1 = sequence correct
err_code  out  3  0 none, 1 timeout, 2 burst length, 3 burst count, 4 protocol
mode_cycles  out  CNT_W  total cycles with mode=1 in the last run (saturating)
run_count  out  CNT_W  number of completed mode bursts in the last run (saturating)

Behaviour:
- Interface: reset is synchronous, active-high, on clock; clock is clock. All outputs are registered.
- Reset values: bist_start=0, busy=0, done=0, pass=0, err_code=0, mode_cycles=0, run_count=0, state=IDLE. Reset has priority over every other input, including mid-run. bist_start goes low on the cycle after reset.
- States: IDLE, START, ACTIVE, WAIT_END, DONE, ERROR.
- IDLE: bist_start=0. On req=1, clear pass, err_code and the counters, clear the watchdog, set busy=1 and go to START.
- START: bist_start=1. It is held high until init=1 is sampled, then dropped and the FSM enters ACTIVE. This guarantees exactly one low-to-high edge per run, because IDLE always provides at least one low cycle first.
- Watchdog: increments every cycle in START, ACTIVE and WAIT_END. When it reaches TIMEOUT, go to ERROR with err_code=1. Width is $clog2(TIMEOUT+1).
- ACTIVE, per cycle:
  - If mode=1, increment the burst-length counter and mode_cycles.
  - On a mode 1->0 transition, the burst length must equal N+1, otherwise ERROR with code 2. On a match, increment run_count and clear the burst-length counter.
  - mode=1 with running=0 is ERROR code 4.
  - init=1 in ACTIVE is ERROR code 4.
  - finish=1: if mode is still 1 or a burst is open, ERROR code 4. Otherwise, if run_count != M+1, ERROR code 3. Otherwise go to WAIT_END.
- WAIT_END: bist_end must be 1 on the cycle immediately after finish, otherwise ERROR code 4. If bist_end=1, go to DONE.
- DONE: done=1 for one cycle, pass=1, busy=0, then IDLE.
- ERROR: done=1 for one cycle, pass=0, busy=0, bist_start=0, err_code held, then IDLE.
- Result outputs (pass, err_code, counters) hold until the next accepted req.
- req while busy is ignored and not queued. A req on the done cycle is ignored; it is accepted from IDLE on the next cycle.
- The first error detected wins. When multiple checks fail in the same cycle, priority is timeout > protocol > burst length > burst count.
- Counters saturate at all-ones and never wrap.
- Nominal latency for N=7, M=10: start to done is 1 + 11*(8+1) + 3 cycles, plus 1-cycle registered-output skew from the controller.

Decomposition:
- Package bist_pkg: state enum, err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_BURST_LEN, ERR_BURST_CNT, ERR_PROTO), and a shared N/M default constant for host and controller.
- Sub-module bist_burst_checker: mode edge detection, burst-length counter, run_count and mode_cycles with saturation. It outputs len_err and burst_done. The FSM and watchdog stay in bist_host.

Test Plan:
1. Nominal with real controller, N=7, M=10: req pulse -> exactly one bist_start rising edge; done pulse; pass=1, err_code=0, mode_cycles=88, run_count=11.
2. Controller model emits a 7-cycle burst in the 3rd run -> ERROR at that mode falling edge; pass=0, err_code=2, run_count=2.
3. Model emits only 10 bursts then finish -> pass=0, err_code=3, run_count=10.
4. Model never raises init, TIMEOUT=64 -> bist_start high for 64 cycles then low; done; err_code=1.
5. Reset asserted mid-ACTIVE -> next cycle all outputs 0, state IDLE. A new req then gives a full nominal pass.
6. req held high continuously, plus req during busy -> only one run per IDLE visit. Back-to-back runs each produce a fresh bist_start edge, and both pass=1.
